// File: rtl/swervolf_mem_arbiter.sv
// 2:1 AXI4 arbiter sharing the DDR2 memory port between s0 (CPU) and s1 (DMA/loader).
// Optional MEM_ARB_INIT_GATE_EN adds i_ram_init_done, which holds off new grants until memory init completes.
module swervolf_mem_arbiter #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
`ifdef MEM_ARB_INIT_GATE_EN
    input  logic                    i_ram_init_done,
`endif
    // master s0
    input  logic [ID_WIDTH-1:0]     s0_awid,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [7:0]              s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [ID_WIDTH-1:0]     s0_bid,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    input  logic [ID_WIDTH-1:0]     s0_arid,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [ID_WIDTH-1:0]     s0_rid,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    // master s1
    input  logic [ID_WIDTH-1:0]     s1_awid,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [7:0]              s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [ID_WIDTH-1:0]     s1_bid,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    input  logic [ID_WIDTH-1:0]     s1_arid,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [ID_WIDTH-1:0]     s1_rid,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    // memory side
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awlock,
    output logic [3:0]              m_awcache,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awregion,
    output logic [3:0]              m_awqos,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arlock,
    output logic [3:0]              m_arcache,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arregion,
    output logic [3:0]              m_arqos,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    // FSM state observation
    output logic [1:0]              wr_state,
    output logic [1:0]              rd_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid
    // never depends on ready, and the granted master's ready is the memory's ready.
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

    wr_state_t wr_st;
    rd_state_t rd_st;
    logic      wr_grant, wr_last, wr_pend;
    logic      rd_grant, rd_last, rd_pend;
    logic      arb_en;

`ifdef MEM_ARB_INIT_GATE_EN
    assign arb_en = i_ram_init_done;
`else
    assign arb_en = 1'b1;
`endif

    // wr_pend marks the arbitration cycle: grant is latched, address phase starts next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_st    <= W_IDLE;
            wr_grant <= 1'b0;
            wr_last  <= 1'b1;
            wr_pend  <= 1'b0;
        end else begin
            case (wr_st)
                W_IDLE: begin
                    if (!arb_en) begin
                        wr_pend <= 1'b0;
                    end else if (wr_pend) begin
                        wr_pend <= 1'b0;
                        wr_st   <= W_ADDR;
                    end else if (s0_awvalid || s1_awvalid) begin
                        wr_grant <= (s0_awvalid && s1_awvalid) ? ~wr_last : s1_awvalid;
                        wr_pend  <= 1'b1;
                    end
                end
                W_ADDR: if (m_awvalid && m_awready) wr_st <= W_DATA;
                W_DATA: if (m_wvalid && m_wready && m_wlast) wr_st <= W_RESP;
                W_RESP: begin
                    if (m_bvalid && m_bready) begin
                        wr_last <= wr_grant;
                        wr_st   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_st    <= R_IDLE;
            rd_grant <= 1'b0;
            rd_last  <= 1'b1;
            rd_pend  <= 1'b0;
        end else begin
            case (rd_st)
                R_IDLE: begin
                    if (!arb_en) begin
                        rd_pend <= 1'b0;
                    end else if (rd_pend) begin
                        rd_pend <= 1'b0;
                        rd_st   <= R_ADDR;
                    end else if (s0_arvalid || s1_arvalid) begin
                        rd_grant <= (s0_arvalid && s1_arvalid) ? ~rd_last : s1_arvalid;
                        rd_pend  <= 1'b1;
                    end
                end
                R_ADDR: if (m_arvalid && m_arready) rd_st <= R_DATA;
                R_DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        rd_last <= rd_grant;
                        rd_st   <= R_IDLE;
                    end
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

    assign wr_state = wr_st;
    assign rd_state = rd_st;

    // write address
    assign m_awid     = wr_grant ? s1_awid    : s0_awid;
    assign m_awaddr   = wr_grant ? s1_awaddr  : s0_awaddr;
    assign m_awlen    = wr_grant ? s1_awlen   : s0_awlen;
    assign m_awsize   = wr_grant ? s1_awsize  : s0_awsize;
    assign m_awburst  = wr_grant ? s1_awburst : s0_awburst;
    assign m_awvalid  = (wr_st == W_ADDR) && (wr_grant ? s1_awvalid : s0_awvalid);
    assign s0_awready = (wr_st == W_ADDR) && !wr_grant && m_awready;
    assign s1_awready = (wr_st == W_ADDR) &&  wr_grant && m_awready;
    assign m_awlock   = 1'b0;
    assign m_awcache  = 4'd0;
    assign m_awprot   = 3'd0;
    assign m_awregion = 4'd0;
    assign m_awqos    = 4'd0;

    // write data
    assign m_wdata   = wr_grant ? s1_wdata : s0_wdata;
    assign m_wstrb   = wr_grant ? s1_wstrb : s0_wstrb;
    assign m_wlast   = wr_grant ? s1_wlast : s0_wlast;
    assign m_wvalid  = (wr_st == W_DATA) && (wr_grant ? s1_wvalid : s0_wvalid);
    assign s0_wready = (wr_st == W_DATA) && !wr_grant && m_wready;
    assign s1_wready = (wr_st == W_DATA) &&  wr_grant && m_wready;

    // write response
    assign s0_bid    = m_bid;
    assign s0_bresp  = m_bresp;
    assign s1_bid    = m_bid;
    assign s1_bresp  = m_bresp;
    assign s0_bvalid = (wr_st == W_RESP) && !wr_grant && m_bvalid;
    assign s1_bvalid = (wr_st == W_RESP) &&  wr_grant && m_bvalid;
    assign m_bready  = (wr_st == W_RESP) && (wr_grant ? s1_bready : s0_bready);

    // read address
    assign m_arid     = rd_grant ? s1_arid    : s0_arid;
    assign m_araddr   = rd_grant ? s1_araddr  : s0_araddr;
    assign m_arlen    = rd_grant ? s1_arlen   : s0_arlen;
    assign m_arsize   = rd_grant ? s1_arsize  : s0_arsize;
    assign m_arburst  = rd_grant ? s1_arburst : s0_arburst;
    assign m_arvalid  = (rd_st == R_ADDR) && (rd_grant ? s1_arvalid : s0_arvalid);
    assign s0_arready = (rd_st == R_ADDR) && !rd_grant && m_arready;
    assign s1_arready = (rd_st == R_ADDR) &&  rd_grant && m_arready;
    assign m_arlock   = 1'b0;
    assign m_arcache  = 4'd0;
    assign m_arprot   = 3'd0;
    assign m_arregion = 4'd0;
    assign m_arqos    = 4'd0;

    // read data
    assign s0_rid    = m_rid;
    assign s0_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rid    = m_rid;
    assign s1_rdata  = m_rdata;
    assign s1_rresp  = m_rresp;
    assign s1_rlast  = m_rlast;
    assign s0_rvalid = (rd_st == R_DATA) && !rd_grant && m_rvalid;
    assign s1_rvalid = (rd_st == R_DATA) &&  rd_grant && m_rvalid;
    assign m_rready  = (rd_st == R_DATA) && (rd_grant ? s1_rready : s0_rready);

endmodule

// File: doc/swervolf_mem_arbiter.md
Name: swervolf_mem_arbiter

Overview:
- 2:1 AXI4 arbiter that shares the single DDR2 memory AXI port between the CPU master (port s0) and a secondary master (port s1, e.g. a DMA or debug loader).
- Sits in the core clock domain, upstream of the AXI clock-domain crossing into the memory controller.
- Read and write directions are arbitrated independently: round-robin, one outstanding burst per direction, responses routed by the held grant.

Parameters:
- ID_WIDTH, 6, AXI ID width on all ports; IDs pass through unmodified.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- s0_aw*/s1_aw*  in/out  id,addr,len[7:0],size[2:0],burst[1:0],valid in; ready out  write address from each master.
- s0_w*/s1_w*  in/out  data,strb,last,valid in; ready out  write data.
- s0_b*/s1_b*  out/in  id,resp[1:0],valid out; ready in  write response.
- s0_ar*/s1_ar*  in/out  same fields as aw  read address.
- s0_r*/s1_r*  out/in  id,data,resp[1:0],last,valid out; ready in  read data.
- m_aw*, m_w*, m_b*, m_ar*, m_r*  mirror  same fields  single master port toward memory.

Behaviour:
- Reset: all valid/ready outputs 0; both FSMs in IDLE; round-robin pointers wr_last=1, rd_last=1, so s0 wins the first contention.
- Write FSM, states: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: if any sX_awvalid, latch grant (round-robin: prefer the master not equal to wr_last when both request; otherwise the sole requester); go to W_ADDR in the next cycle. No ready is asserted in W_IDLE.
  - W_ADDR: m_aw* = granted s_aw*; granted s_awready = m_awready; other master's awready = 0. On the AW handshake go to W_DATA.
  - W_DATA: W channel muxed from the granted master; on a handshake with wlast=1 go to W_RESP. W beats before the AW handshake are not forwarded (wready=0 outside W_DATA).
  - W_RESP: m_b* routed to the granted master; m_bready = granted bready. On the B handshake: wr_last <= grant, go to W_IDLE.
- Read FSM, states: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - Same arbitration rule as the write FSM, using rd_last.
  - R_DATA: m_r* routed to the granted master. Leave R_DATA on the R handshake with rlast=1; rd_last <= grant.
- Non-granted masters see awready/wready/arready/bvalid/rvalid = 0.
- Latency: request to m_*valid is exactly 2 cycles (1 cycle arbitrate, then drive). Back-to-back bursts have 1 idle cycle between the final handshake and the next arbitration.
- Read and write may be in flight simultaneously, from the same or different masters.
- A master deasserting valid before ready is an AXI violation and is not handled.
- rstn asserted mid-burst returns both FSMs to IDLE immediately and drops all valids; the downstream is reset by the same reset.
- m_awlock/cache/prot/region/qos and ar equivalents are driven 0.

Optional Feature:
- MEM_ARB_INIT_GATE_EN defined: adds input i_ram_init_done (1 bit). Both FSMs stay in IDLE (no grant, no readies) while i_ram_init_done=0. If it falls mid-burst, the current burst completes and further grants are blocked.
- Macro undefined: the port is absent and grants are unconditional.

Test Plan:
- Only s0 issues a read, araddr=0x100, arlen=3 -> m_arvalid 2 cycles after s0_arvalid; 4 R beats reach s0 with rlast on the 4th; s1 sees no rvalid.
- s0 and s1 assert awvalid in the same cycle after reset -> s0 granted first; s1 is granted only after s0's B handshake; write data is not interleaved.
- Both masters continuously request reads, 4 bursts each -> grant order s0,s1,s0,s1,...
- s0 write (awlen=1) and s1 read (arlen=7) issued in the same cycle -> both proceed concurrently; B goes to s0, all 8 R beats to s1.
- m_bready stalls: B held valid 5 cycles with s0_bready=0 -> FSM stays in W_RESP; a pending s1 aw is not granted until the handshake.
- rstn pulsed low during R_DATA beat 2 of 8 -> all outputs 0 asynchronously; after release s0 wins the next contention. With MEM_ARB_INIT_GATE_EN: i_ram_init_done=0 -> no arready for 20 cycles; goes to 1 -> grant within 2 cycles.
